// File: rtl/boot_pkg.sv
`default_nettype none
// ============================================================================
// Module      : boot_pkg
// Description : Shared constants and UART receiver state encoding for the
//               boot loader. The PARITY state exists only when
//               BOOT_UART_PARITY_EN is defined.
// Revision    : 1.0 - initial release
// ============================================================================
package boot_pkg;

  // Instruction word width used by the instruction memory boot port
  localparam int CFG_INST_DATA_WIDTH = 32;

  // Bytes packed into one instruction word (little-endian)
  localparam int BYTES_PER_WORD = 4;

  // Parity polarity: 0 = even parity (total ones incl. parity bit is even)
  localparam logic PARITY_ODD = 1'b0;

  // UART receiver states
  typedef enum logic [2:0] {
    ST_IDLE   = 3'd0,
    ST_START  = 3'd1,
    ST_DATA   = 3'd2,
    ST_STOP   = 3'd3
`ifdef BOOT_UART_PARITY_EN
    ,
    ST_PARITY = 3'd4
`endif
  } uart_state_e;

endpackage
`default_nettype wire

// File: rtl/uart_rx.sv
`default_nettype none
// ============================================================================
// Module      : uart_rx
// Description : UART byte receiver: 2-flop synchronizer, falling-edge start
//               detect, mid-bit sampling, LSB-first data, stop check.
//               Optional even-parity bit when BOOT_UART_PARITY_EN is defined.
// Revision    : 1.0 - initial release
// ============================================================================
module uart_rx
  import boot_pkg::*;
#(
  parameter int CLKS_PER_BIT = 868
) (
  input  logic       clk,
  input  logic       reset_n,
  input  logic       rx_in,
  output logic [7:0] byte_data,
  output logic       byte_valid,
  output logic       frame_err
`ifdef BOOT_UART_PARITY_EN
  ,
  output logic       parity_err
`endif
);

  localparam int CNT_W = $clog2(CLKS_PER_BIT);
  localparam logic [CNT_W-1:0] BIT_LAST  = CNT_W'(CLKS_PER_BIT - 1);
  localparam logic [CNT_W-1:0] HALF_LAST = CNT_W'(CLKS_PER_BIT / 2 - 1);

  uart_state_e      state_q, state_d;
  logic             rx_meta_q, rx_sync_q, rx_prev_q;
  logic [CNT_W-1:0] cnt_q, cnt_d;
  logic [2:0]       bit_q, bit_d;
  logic [7:0]       shift_q, shift_d;
  logic             byte_valid_q, byte_valid_d;
  logic             frame_err_q, frame_err_d;
`ifdef BOOT_UART_PARITY_EN
  logic             par_bit_q, par_bit_d;
  logic             parity_err_q, parity_err_d;
`endif

  // Synchronizer, FSM state and datapath registers
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      rx_meta_q    <= 1'b1;
      rx_sync_q    <= 1'b1;
      rx_prev_q    <= 1'b1;
      state_q      <= ST_IDLE;
      cnt_q        <= '0;
      bit_q        <= '0;
      shift_q      <= '0;
      byte_valid_q <= 1'b0;
      frame_err_q  <= 1'b0;
`ifdef BOOT_UART_PARITY_EN
      par_bit_q    <= 1'b0;
      parity_err_q <= 1'b0;
`endif
    end else begin
      rx_meta_q    <= rx_in;
      rx_sync_q    <= rx_meta_q;
      rx_prev_q    <= rx_sync_q;
      state_q      <= state_d;
      cnt_q        <= cnt_d;
      bit_q        <= bit_d;
      shift_q      <= shift_d;
      byte_valid_q <= byte_valid_d;
      frame_err_q  <= frame_err_d;
`ifdef BOOT_UART_PARITY_EN
      par_bit_q    <= par_bit_d;
      parity_err_q <= parity_err_d;
`endif
    end
  end

  // Next-state logic: bit timing, sampling and end-of-frame strobes
  always_comb begin
    state_d      = state_q;
    cnt_d        = cnt_q;
    bit_d        = bit_q;
    shift_d      = shift_q;
    byte_valid_d = 1'b0;
    frame_err_d  = 1'b0;
`ifdef BOOT_UART_PARITY_EN
    par_bit_d    = par_bit_q;
    parity_err_d = 1'b0;
`endif
    unique case (state_q)
      ST_IDLE: begin
        if (rx_prev_q && !rx_sync_q) begin
          state_d = ST_START;
          cnt_d   = '0;
        end
      end
      ST_START: begin
        if (cnt_q == HALF_LAST) begin
          cnt_d   = '0;
          bit_d   = '0;
          // A line back high at mid start bit is a glitch, not a frame
          state_d = rx_sync_q ? ST_IDLE : ST_DATA;
        end else begin
          cnt_d = cnt_q + CNT_W'(1);
        end
      end
      ST_DATA: begin
        if (cnt_q == BIT_LAST) begin
          cnt_d   = '0;
          shift_d = {rx_sync_q, shift_q[7:1]};
          if (bit_q == 3'd7) begin
`ifdef BOOT_UART_PARITY_EN
            state_d = ST_PARITY;
`else
            state_d = ST_STOP;
`endif
          end else begin
            bit_d = bit_q + 3'd1;
          end
        end else begin
          cnt_d = cnt_q + CNT_W'(1);
        end
      end
`ifdef BOOT_UART_PARITY_EN
      ST_PARITY: begin
        if (cnt_q == BIT_LAST) begin
          cnt_d     = '0;
          par_bit_d = rx_sync_q;
          state_d   = ST_STOP;
        end else begin
          cnt_d = cnt_q + CNT_W'(1);
        end
      end
`endif
      ST_STOP: begin
        if (cnt_q == BIT_LAST) begin
          cnt_d   = '0;
          state_d = ST_IDLE;
          if (!rx_sync_q) begin
            frame_err_d = 1'b1;
`ifdef BOOT_UART_PARITY_EN
          end else if (par_bit_q != ((^shift_q) ^ PARITY_ODD)) begin
            parity_err_d = 1'b1;
`endif
          end else begin
            byte_valid_d = 1'b1;
          end
        end else begin
          cnt_d = cnt_q + CNT_W'(1);
        end
      end
      default: state_d = ST_IDLE;
    endcase
  end

  assign byte_data  = shift_q;
  assign byte_valid = byte_valid_q;
  assign frame_err  = frame_err_q;
`ifdef BOOT_UART_PARITY_EN
  assign parity_err = parity_err_q;
`endif

endmodule
`default_nettype wire

// File: rtl/boot_loader.sv
`default_nettype none
// ============================================================================
// Module      : boot_loader
// Description : Receives a program image over UART and packs bytes
//               little-endian into 32-bit words for the instruction memory
//               boot port. Handles word counting, overflow, inter-byte
//               timeout and sticky error flags.
//               Optional macro: BOOT_UART_PARITY_EN (even parity + port).
// Revision    : 1.0 - initial release
// ============================================================================
module boot_loader
  import boot_pkg::*;
#(
  parameter int INST_DATA_WIDTH   = CFG_INST_DATA_WIDTH,
  parameter int INST_CMD_COUNT    = 100,
  parameter int CLKS_PER_BIT      = 868,
  parameter int BYTE_TIMEOUT_CLKS = 100000
) (
  input  logic                               clk,
  input  logic                               reset_n,
  input  logic                               boost_en,
  input  logic                               uart_rx,
  output logic [INST_DATA_WIDTH-1:0]         rx_boost_inst_data_in,
  output logic                               rx_boost_inst_wr_req,
  output logic [$clog2(INST_CMD_COUNT+1)-1:0] boot_word_count,
  output logic                               boot_overflow,
  output logic                               boot_frame_err
`ifdef BOOT_UART_PARITY_EN
  ,
  output logic                               boot_parity_err
`endif
);

  localparam int CW = $clog2(INST_CMD_COUNT + 1);
  localparam int TW = $clog2(BYTE_TIMEOUT_CLKS);
  localparam logic [CW-1:0] CNT_MAX  = CW'(INST_CMD_COUNT);
  localparam logic [TW-1:0] TMO_LAST = TW'(BYTE_TIMEOUT_CLKS - 1);
  localparam logic [1:0]    IDX_LAST = 2'(BYTES_PER_WORD - 1);

  logic [7:0] byte_data;
  logic       byte_valid;
  logic       frame_err;
`ifdef BOOT_UART_PARITY_EN
  logic       parity_err;
`endif

  uart_rx #(
    .CLKS_PER_BIT (CLKS_PER_BIT)
  ) u_uart_rx (
    .clk        (clk),
    .reset_n    (reset_n),
    .rx_in      (uart_rx),
    .byte_data  (byte_data),
    .byte_valid (byte_valid),
    .frame_err  (frame_err)
`ifdef BOOT_UART_PARITY_EN
    ,
    .parity_err (parity_err)
`endif
  );

  logic                       boost_q;
  logic [1:0]                 idx_q, idx_d;
  logic [INST_DATA_WIDTH-1:0] part_q, part_d;
  logic [INST_DATA_WIDTH-1:0] data_q, data_d;
  logic                       wr_q, wr_d;
  logic [CW-1:0]              count_q, count_d;
  logic                       ovf_q, ovf_d;
  logic                       ferr_q, ferr_d;
  logic [TW-1:0]              tmo_q, tmo_d;
`ifdef BOOT_UART_PARITY_EN
  logic                       perr_q, perr_d;
`endif
  logic                       boost_rise;

  assign boost_rise = boost_en && !boost_q;

  // Packer, counter, timeout and sticky flag registers
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      boost_q <= 1'b0;
      idx_q   <= '0;
      part_q  <= '0;
      data_q  <= '0;
      wr_q    <= 1'b0;
      count_q <= '0;
      ovf_q   <= 1'b0;
      ferr_q  <= 1'b0;
      tmo_q   <= '0;
`ifdef BOOT_UART_PARITY_EN
      perr_q  <= 1'b0;
`endif
    end else begin
      boost_q <= boost_en;
      idx_q   <= idx_d;
      part_q  <= part_d;
      data_q  <= data_d;
      wr_q    <= wr_d;
      count_q <= count_d;
      ovf_q   <= ovf_d;
      ferr_q  <= ferr_d;
      tmo_q   <= tmo_d;
`ifdef BOOT_UART_PARITY_EN
      perr_q  <= perr_d;
`endif
    end
  end

  // Session clear, byte packing, word write/overflow and partial-word timeout
  always_comb begin
    idx_d   = idx_q;
    part_d  = part_q;
    data_d  = data_q;
    wr_d    = 1'b0;
    count_d = count_q;
    ovf_d   = ovf_q;
    ferr_d  = ferr_q;
    tmo_d   = tmo_q;
`ifdef BOOT_UART_PARITY_EN
    perr_d  = perr_q;
`endif
    if (boost_rise) begin
      // New session: the clear wins over a coincident byte
      idx_d   = '0;
      part_d  = '0;
      count_d = '0;
      ovf_d   = 1'b0;
      ferr_d  = 1'b0;
      tmo_d   = '0;
`ifdef BOOT_UART_PARITY_EN
      perr_d  = 1'b0;
`endif
    end else begin
      if (frame_err) ferr_d = 1'b1;
`ifdef BOOT_UART_PARITY_EN
      if (parity_err) perr_d = 1'b1;
`endif
      if (!boost_en) begin
        // Outside boot mode any partial word is abandoned; count is held
        idx_d  = '0;
        part_d = '0;
        tmo_d  = '0;
      end else if (byte_valid) begin
        tmo_d = '0;
        if (idx_q == IDX_LAST) begin
          if (count_q < CNT_MAX) begin
            data_d  = {byte_data, part_q[23:0]};
            wr_d    = 1'b1;
            count_d = count_q + CW'(1);
          end else begin
            ovf_d = 1'b1;
          end
          idx_d  = '0;
          part_d = '0;
        end else begin
          part_d[{idx_q, 3'b000} +: 8] = byte_data;
          idx_d = idx_q + 2'd1;
        end
      end else if (idx_q != 2'd0) begin
        if (tmo_q == TMO_LAST) begin
          idx_d  = '0;
          part_d = '0;
          tmo_d  = '0;
        end else begin
          tmo_d = tmo_q + TW'(1);
        end
      end
    end
  end

  assign rx_boost_inst_data_in = data_q;
  assign rx_boost_inst_wr_req  = wr_q;
  assign boot_word_count       = count_q;
  assign boot_overflow         = ovf_q;
  assign boot_frame_err        = ferr_q;
`ifdef BOOT_UART_PARITY_EN
  assign boot_parity_err       = perr_q;
`endif

endmodule
`default_nettype wire

// File: tb/tb_boot_loader.sv
`default_nettype none
// ============================================================================
// Module      : tb_boot_loader
// Description : Self-checking bench for boot_loader. A byte/word-level model
//               predicts written words, count and flags from the stream of
//               bytes the bench sends.
// Revision    : 1.0 - initial release
// ============================================================================
module tb_boot_loader;
  import boot_pkg::*;

  localparam int CLKS = 16;
  localparam int NCMD = 3;
  localparam int TMO  = 400;
  localparam int CW   = $clog2(NCMD + 1);

  logic          clk = 1'b0;
  logic          reset_n = 1'b0;
  logic          boost_en = 1'b0;
  logic          uart_rx = 1'b1;
  logic [31:0]   data_out;
  logic          wr_req;
  logic [CW-1:0] word_count;
  logic          overflow;
  logic          frame_err;
`ifdef BOOT_UART_PARITY_EN
  logic          parity_err;
`endif

  boot_loader #(
    .INST_DATA_WIDTH   (32),
    .INST_CMD_COUNT    (NCMD),
    .CLKS_PER_BIT      (CLKS),
    .BYTE_TIMEOUT_CLKS (TMO)
  ) dut (
    .clk                   (clk),
    .reset_n               (reset_n),
    .boost_en              (boost_en),
    .uart_rx               (uart_rx),
    .rx_boost_inst_data_in (data_out),
    .rx_boost_inst_wr_req  (wr_req),
    .boot_word_count       (word_count),
    .boot_overflow         (overflow),
    .boot_frame_err        (frame_err)
`ifdef BOOT_UART_PARITY_EN
    ,
    .boot_parity_err       (parity_err)
`endif
  );

  always #5 clk = ~clk;

  int checks = 0;
  int errors = 0;

  task automatic check(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  // ---------------- reference model ----------------
  logic [7:0]  m_bytes[$];
  int          m_count;
  bit          m_ovf;
  logic [31:0] m_last;
  logic [31:0] exp_q[$];
  logic [31:0] got_q[$];

  task automatic model_session();
    m_bytes.delete();
    m_count = 0;
    m_ovf   = 1'b0;
  endtask

  task automatic model_byte(input logic [7:0] b);
    if (boost_en) begin
      m_bytes.push_back(b);
      if (m_bytes.size() == 4) begin
        if (m_count < NCMD) begin
          m_last = {m_bytes[3], m_bytes[2], m_bytes[1], m_bytes[0]};
          exp_q.push_back(m_last);
          m_count++;
        end else begin
          m_ovf = 1'b1;
        end
        m_bytes.delete();
      end
    end
  endtask

  // ---------------- write monitor ----------------
  logic prev_wr = 1'b0;
  always @(negedge clk) begin
    if (wr_req) begin
      got_q.push_back(data_out);
      check("wr_single_cycle", {63'd0, prev_wr}, 64'd0);
    end
    prev_wr = wr_req;
  end

  // ---------------- line driver ----------------
  task automatic drive_bit(input logic v);
    uart_rx = v;
    repeat (CLKS) @(negedge clk);
  endtask

  task automatic send_frame(input logic [7:0] b, input logic stop_b, input logic par_b);
    @(negedge clk);
    drive_bit(1'b0);
    for (int i = 0; i < 8; i++) drive_bit(b[i]);
`ifdef BOOT_UART_PARITY_EN
    drive_bit(par_b);
`else
    if (par_b) begin end
`endif
    drive_bit(stop_b);
    uart_rx = 1'b1;
    repeat (8) @(negedge clk);
  endtask

  task automatic send_good(input logic [7:0] b);
    send_frame(b, 1'b1, (^b) ^ PARITY_ODD);
    model_byte(b);
  endtask

  task automatic compare_writes(input string tag);
    check({tag, "_nwords"}, 64'(got_q.size()), 64'(exp_q.size()));
    for (int i = 0; i < exp_q.size() && i < got_q.size(); i++)
      check({tag, "_word"}, {32'd0, got_q[i]}, {32'd0, exp_q[i]});
  endtask

  task automatic check_status(input string tag);
    check({tag, "_count"}, 64'(word_count), 64'(m_count));
    check({tag, "_ovf"}, 64'(overflow), 64'(m_ovf));
  endtask

  task automatic session_restart();
    @(negedge clk) boost_en = 1'b0;
    repeat (3) @(negedge clk);
    boost_en = 1'b1;
    model_session();
    repeat (3) @(negedge clk);
  endtask

  initial begin
    m_last = '0;
    model_session();

    // Reset state
    repeat (3) @(negedge clk);
    check("rst_data", 64'(data_out), 64'd0);
    check("rst_wr", 64'(wr_req), 64'd0);
    check("rst_count", 64'(word_count), 64'd0);
    check("rst_ovf", 64'(overflow), 64'd0);
    check("rst_ferr", 64'(frame_err), 64'd0);
    reset_n = 1'b1;
    repeat (3) @(negedge clk);

    // Basic word
    boost_en = 1'b1;
    repeat (3) @(negedge clk);
    send_good(8'h13); send_good(8'h05); send_good(8'h10); send_good(8'h00);
    compare_writes("basic");
    check("basic_data", 64'(data_out), 64'h0010_0513);
    check_status("basic");

    // Short low glitch must not start a byte
    @(negedge clk) uart_rx = 1'b0;
    repeat (CLKS / 4) @(negedge clk);
    uart_rx = 1'b1;
    repeat (3 * CLKS) @(negedge clk);
    compare_writes("glitch");
    check("glitch_ferr", 64'(frame_err), 64'd0);
    check("glitch_hold", 64'(data_out), 64'h0010_0513);
    check_status("glitch");

    // Bad stop bit: flag set, byte dropped, next word intact
    begin
      logic [7:0] b;
      b = 8'($urandom);
      send_frame(b, 1'b0, (^b) ^ PARITY_ODD);
    end
    check("frame_ferr", 64'(frame_err), 64'd1);
    for (int i = 0; i < 4; i++) send_good(8'($urandom));
    compare_writes("after_ferr");
    check_status("after_ferr");

    // New session clears count and flags
    session_restart();
    check("sess_ferr", 64'(frame_err), 64'd0);
    check_status("sess");

    // Partial word discarded after timeout
    send_good(8'hAA); send_good(8'hBB);
    repeat (TMO + 100) @(negedge clk);
    m_bytes.delete();
    send_good(8'hEF); send_good(8'hBE); send_good(8'hAD); send_good(8'hDE);
    compare_writes("timeout");
    check("timeout_data", 64'(data_out), 64'hDEAD_BEEF);
    check_status("timeout");

    // Random words with random gaps, running past the word limit
    for (int w = 0; w < 3; w++) begin
      for (int k = 0; k < 4; k++) begin
        send_good(8'($urandom));
        repeat ($urandom_range(0, 60)) @(negedge clk);
      end
    end
    compare_writes("rand");
    check("rand_data", 64'(data_out), 64'(m_last));
    check_status("rand");

    // boost_en falling mid-word: partial dropped, count held, bytes ignored
    send_good(8'($urandom)); send_good(8'($urandom));
    @(negedge clk) boost_en = 1'b0;
    m_bytes.delete();
    repeat (5) @(negedge clk);
    send_good(8'($urandom));
    check_status("fall_hold");
    boost_en = 1'b1;
    model_session();
    repeat (3) @(negedge clk);
    check_status("rise_clear");
    for (int k = 0; k < 4; k++) send_good(8'($urandom));
    compare_writes("fall");
    check_status("fall");

`ifdef BOOT_UART_PARITY_EN
    // Even parity violation: flag set, byte dropped
    send_frame(8'h01, 1'b1, 1'b0);
    check("parity_err", 64'(parity_err), 64'd1);
    for (int k = 0; k < 4; k++) send_good(8'($urandom));
    compare_writes("parity");
    check_status("parity");
`endif

    // Reset mid-frame, then reception resumes
    @(negedge clk);
    uart_rx = 1'b0;
    repeat (3 * CLKS) @(negedge clk);
    reset_n = 1'b0;
    uart_rx = 1'b1;
    repeat (2) @(negedge clk);
    check("midrst_count", 64'(word_count), 64'd0);
    check("midrst_data", 64'(data_out), 64'd0);
    reset_n = 1'b1;
    model_session();
    repeat (3 * CLKS) @(negedge clk);
    for (int k = 0; k < 4; k++) send_good(8'($urandom));
    compare_writes("midrst");
    check("midrst_last", 64'(data_out), 64'(m_last));
    check_status("midrst");

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
`default_nettype wire
